// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, register map and state encoding shared by cpu_run_ctrl
package cpu_ctrl_pkg;

  localparam logic [7:0] RESET_CPU = 8'd0;
  localparam logic [7:0] START_CPU = 8'd1;
  localparam logic [7:0] PAUSE_CPU = 8'd2;
  localparam logic [7:0] WRITE_MEM = 8'd3;
  localparam logic [7:0] STEP      = 8'd4;

  localparam logic [15:0] CMD      = 16'd0;
  localparam logic [15:0] MEM_ADDR = 16'd1;
  localparam logic [15:0] MEM_DATA = 16'd2;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_PAUSED  = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSING = 3'd3,
    ST_STEP    = 3'd4,
    ST_MEMWR   = 3'd5
  } run_state_t;

  // A zero speed setting runs at the fastest rate rather than stalling.
  function automatic logic [3:0] eff_delay(input logic [3:0] d);
    return (d == 4'd0) ? 4'd1 : d;
  endfunction

endpackage

// File: rtl/ce_timer.sv
// rtl/ce_timer.sv - prescaler plus period counter producing the periodic CPU clock-enable
module ce_timer #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] delay_eff,
  output logic       ce
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre;
  logic [3:0]    per;
  logic          wrap;

  assign wrap = enable && (pre == PW'(PRESCALE - 1));
  // >= rather than == so a mid-period drop in delay fires on the next wrap.
  assign ce   = wrap && (({1'b0, per} + 5'd1) >= {1'b0, delay_eff});

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre <= '0;
      per <= '0;
    end else if (enable) begin
      pre <= wrap ? '0 : pre + 1'b1;
      if (ce)
        per <= '0;
      else if (wrap)
        per <= per + 4'd1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU run/pause/step sequencer and host memory-write gate; STEP built with CPU_RUN_CTRL_STEP_EN
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int RST_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  delay,
  input  logic        write,
  input  logic [15:0] address,
  input  logic [15:0] writedata,
  input  logic        read,
  output logic [15:0] readdata,
  input  logic        cpu_sync,
  output logic        cpu_ce,
  output logic        cpu_rst,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata
);

  localparam int RW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  run_state_t    state, state_nxt;
  logic [3:0]    d_eff;
  logic          cmd_wr, cmd_reset, cmd_bad;
  logic [7:0]    op;
  logic [RW-1:0] rst_cnt;
  logic          rst_done;
  logic          err;
  logic          stepped;
  logic          timer_en, timer_clr, ce;

  assign d_eff     = eff_delay(delay);
  assign cmd_wr    = write && (address == CMD);
  assign op        = writedata[7:0];
  assign cmd_reset = cmd_wr && (op == RESET_CPU);
  assign rst_done  = (rst_cnt == RW'(RST_HOLD - 1));
  assign cpu_ce    = ce;

  ce_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clr),
    .enable    (timer_en),
    .delay_eff (d_eff),
    .ce        (ce)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_RESET;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_bad   = 1'b0;
    if (cmd_wr && (op != RESET_CPU)) begin
      cmd_bad = 1'b1;
      if (state == ST_PAUSED) begin
        case (op)
          START_CPU: begin state_nxt = ST_RUN;   cmd_bad = 1'b0; end
          WRITE_MEM: begin state_nxt = ST_MEMWR; cmd_bad = 1'b0; end
`ifdef CPU_RUN_CTRL_STEP_EN
          STEP:      begin state_nxt = ST_STEP;  cmd_bad = 1'b0; end
`endif
          default: ;
        endcase
      end else if ((state == ST_RUN) && (op == PAUSE_CPU)) begin
        state_nxt = ST_PAUSING;
        cmd_bad   = 1'b0;
      end
    end
    case (state)
      ST_RESET:   if (rst_done) state_nxt = ST_PAUSED;
      ST_PAUSING: if (cpu_sync && !ce) state_nxt = ST_PAUSED;
`ifdef CPU_RUN_CTRL_STEP_EN
      ST_STEP:    if (stepped && cpu_sync && !ce) state_nxt = ST_PAUSED;
`endif
      ST_MEMWR:   state_nxt = ST_PAUSED;
      default: ;
    endcase
    if (cmd_reset)
      state_nxt = ST_RESET;
  end

  always_comb begin
    cpu_rst   = (state == ST_RESET);
    mem_we    = (state == ST_MEMWR);
    timer_en  = (state == ST_RUN) || (state == ST_PAUSING);
`ifdef CPU_RUN_CTRL_STEP_EN
    timer_en  = timer_en || (state == ST_STEP);
`endif
    timer_clr = (state == ST_PAUSED) && ((state_nxt == ST_RUN) || (state_nxt == ST_STEP));
  end

`ifdef CPU_RUN_CTRL_STEP_EN
  always_ff @(posedge clk) begin
    if (reset || timer_clr)
      stepped <= 1'b0;
    else if (ce)
      stepped <= 1'b1;
  end
`else
  assign stepped = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt   <= '0;
      err       <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      readdata  <= 16'h0000;
    end else begin
      if (cmd_reset)
        rst_cnt <= '0;
      else if ((state == ST_RESET) && !rst_done)
        rst_cnt <= rst_cnt + 1'b1;
      if (cmd_reset)
        err <= 1'b0;
      else if (cmd_bad)
        err <= 1'b1;
      // A host address write in the strobe cycle takes precedence over the post-increment.
      if (write && (address == MEM_ADDR))
        mem_addr <= writedata;
      else if (mem_we)
        mem_addr <= mem_addr + 16'd1;
      if (write && (address == MEM_DATA))
        mem_wdata <= writedata[7:0];
      if (read)
        readdata <= {8'h00, d_eff, err, state};
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl run, pause, step and memory-write sequencing
module tb_cpu_run_ctrl;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  delay = 4'd0;
  logic        write = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [15:0] writedata = 16'h0000;
  logic        read = 1'b0;
  logic [15:0] readdata;
  logic        cpu_sync = 1'b0;
  logic        cpu_ce, cpu_rst, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct { logic [15:0] a; logic [7:0] d; int t; } mw_t;
  int  ce_q[$];
  mw_t mw_q[$];

  cpu_run_ctrl #(.PRESCALE(4), .RST_HOLD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .delay     (delay),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .cpu_sync  (cpu_sync),
    .cpu_ce    (cpu_ce),
    .cpu_rst   (cpu_rst),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cpu_ce === 1'b1) begin
      int t;
      tests++;
      if (ce_q.size() == 0) begin
        fails++;
        $display("FAIL ce_unexpected: cpu_ce pulse at cycle %0d, none expected", cyc);
      end else begin
        t = ce_q.pop_front();
        if (cyc != t) begin
          fails++;
          $display("FAIL ce_time: cpu_ce at cycle %0d, expected cycle %0d", cyc, t);
        end
      end
    end
    if (mem_we === 1'b1) begin
      mw_t e;
      tests++;
      if (mw_q.size() == 0) begin
        fails++;
        $display("FAIL mem_we_unexpected: mem_we at cycle %0d addr %h", cyc, mem_addr);
      end else begin
        e = mw_q.pop_front();
        if (mem_addr !== e.a || mem_wdata !== e.d || cyc != e.t) begin
          fails++;
          $display("FAIL mem_we: addr %h data %h cycle %0d, expected addr %h data %h cycle %0d",
                   mem_addr, mem_wdata, cyc, e.a, e.d, e.t);
        end
      end
    end
  end

  task automatic step_to(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, output int n);
    write = 1'b1; address = a; writedata = d; n = cyc;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(output logic [15:0] v);
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    v = readdata;
  endtask

  task automatic count_rst(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (cpu_rst !== 1'b1) break;
      n++;
    end
    @(posedge clk); #1;
  endtask

  function automatic void push_run(input int n0, input int p, input int upto);
    for (int t = n0 + p; t <= upto; t += p) ce_q.push_back(t);
  endfunction

  task automatic test_reset;
    int n;
    logic [15:0] v;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (readdata !== 16'h0000 || cpu_rst !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0000 ||
        mem_wdata !== 8'h00 || cpu_ce !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: rd %h rst %b we %b addr %h data %h ce %b, expected 0000 1 0 0000 00 0",
               readdata, cpu_rst, mem_we, mem_addr, mem_wdata, cpu_ce);
    end
    reset = 1'b0;
    count_rst(n);
    tests++;
    if (n != 8) begin fails++; $display("FAIL reset_hold: cpu_rst high %0d cycles, expected 8", n); end
    rd(v);
    tests++;
    if (v !== 16'h0011) begin fails++; $display("FAIL reset_status: readdata %h, expected 0011", v); end
  endtask

  task automatic test_memwr;
    int n;
    logic [15:0] v;
    wr(MEM_ADDR, 16'hFFFF, n);
    wr(MEM_DATA, 16'h12A5, n);
    wr(CMD, {8'h00, WRITE_MEM}, n);
    mw_q.push_back('{16'hFFFF, 8'hA5, n + 1});
    @(posedge clk); #1;
    tests++;
    if (mem_addr !== 16'h0000) begin fails++; $display("FAIL mem_addr_wrap: %h, expected 0000", mem_addr); end
    wr(CMD, {8'h00, WRITE_MEM}, n);
    mw_q.push_back('{16'h0000, 8'hA5, n + 1});
    @(posedge clk); #1;
    tests++;
    if (mem_addr !== 16'h0001) begin fails++; $display("FAIL mem_addr_inc: %h, expected 0001", mem_addr); end
    tests++;
    if (mw_q.size() != 0) begin fails++; $display("FAIL mem_we_missing: %0d strobes outstanding, expected 0", mw_q.size()); end
    rd(v);
    tests++;
    if (v !== 16'h0011) begin fails++; $display("FAIL memwr_status: readdata %h, expected 0011", v); end
  endtask

  task automatic test_run_delay;
    int n, m, t, k;
    logic [15:0] v;
    delay = 4'd3;
    wr(CMD, {8'h00, START_CPU}, n);
    push_run(n, 12, n + 12);
    step_to(n + 17);
    delay = 4'd1;
    t = n + 17;
    while (((t - n) % 4) != 0) t++;
    for (k = t; k < n + 30; k += 4) ce_q.push_back(k);
    step_to(n + 30);
    wr(CMD, {8'h00, RESET_CPU}, m);
    count_rst(k);
    tests++;
    if (k != 8) begin fails++; $display("FAIL run_reset_hold: cpu_rst high %0d cycles, expected 8", k); end
    tests++;
    if (ce_q.size() != 0) begin fails++; $display("FAIL run_ce_missing: %0d pulses outstanding, expected 0", ce_q.size()); end
    rd(v);
    tests++;
    if (v !== 16'h0011) begin fails++; $display("FAIL run_status: readdata %h, expected 0011", v); end
  endtask

  task automatic test_pause;
    int n, m;
    logic [15:0] v;
    delay = 4'd3;
    cpu_sync = 1'b0;
    wr(CMD, {8'h00, START_CPU}, n);
    push_run(n, 12, n + 26);
    step_to(n + 14);
    wr(CMD, {8'h00, PAUSE_CPU}, m);
    step_to(n + 26);
    cpu_sync = 1'b1;
    step_to(n + 27);
    rd(v);
    tests++;
    if (v !== 16'h0031) begin fails++; $display("FAIL pause_status: readdata %h, expected 0031", v); end
    step_to(n + 45);
    tests++;
    if (ce_q.size() != 0) begin fails++; $display("FAIL pause_ce_missing: %0d pulses outstanding, expected 0", ce_q.size()); end
  endtask

  task automatic test_err_reset;
    int n, m, k;
    logic [15:0] v;
    delay = 4'd3;
    cpu_sync = 1'b0;
    wr(CMD, {8'h00, START_CPU}, n);
    step_to(n + 5);
    wr(CMD, {8'h00, WRITE_MEM}, m);
    push_run(n, 12, n + 20);
    step_to(n + 8);
    rd(v);
    tests++;
    if (v !== 16'h003A) begin fails++; $display("FAIL err_set: readdata %h, expected 003a", v); end
    step_to(n + 20);
    wr(CMD, {8'h00, RESET_CPU}, m);
    count_rst(k);
    tests++;
    if (k != 8) begin fails++; $display("FAIL err_reset_hold: cpu_rst high %0d cycles, expected 8", k); end
    rd(v);
    tests++;
    if (v !== 16'h0031) begin fails++; $display("FAIL err_cleared: readdata %h, expected 0031", v); end
    wr(CMD, 16'h0010, m);
    rd(v);
    tests++;
    if (v !== 16'h0039) begin fails++; $display("FAIL err_unknown_op: readdata %h, expected 0039", v); end
    tests++;
    if (ce_q.size() != 0 || mw_q.size() != 0) begin
      fails++;
      $display("FAIL err_outstanding: ce %0d mem %0d outstanding, expected 0 0", ce_q.size(), mw_q.size());
    end
  endtask

  task automatic test_step;
    int n, k;
    logic [15:0] v;
    wr(CMD, {8'h00, RESET_CPU}, n);
    count_rst(k);
    tests++;
    if (k != 8) begin fails++; $display("FAIL step_reset_hold: cpu_rst high %0d cycles, expected 8", k); end
    delay = 4'd2;
    cpu_sync = 1'b1;
    wr(CMD, {8'h00, STEP}, n);
`ifdef CPU_RUN_CTRL_STEP_EN
    ce_q.push_back(n + 8);
`endif
    step_to(n + 12);
    rd(v);
    tests++;
`ifdef CPU_RUN_CTRL_STEP_EN
    if (v !== 16'h0021) begin fails++; $display("FAIL step_status: readdata %h, expected 0021", v); end
`else
    if (v !== 16'h0029) begin fails++; $display("FAIL step_status: readdata %h, expected 0029", v); end
`endif
    step_to(n + 30);
    tests++;
    if (ce_q.size() != 0) begin fails++; $display("FAIL step_ce_missing: %0d pulses outstanding, expected 0", ce_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, tests %0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_memwr();
    test_run_delay();
    test_pause();
    test_err_reset();
    test_step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
